// File: rtl/pmt_lookup_arbiter_pkg.sv
// Shared definitions for the PMT lookup front end.
//   PMT_RD_LAT : fixed SRAM read latency in cycles (depth of the tag pipe)
//   pmt_state_e: lookup-quiesce FSM encoding (RUN / DRAIN / FROZEN)
//   idx_w()    : width of a requester index for a given requester count
package pmt_pkg;

    localparam int PMT_RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } pmt_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmt_lookup_arbiter_if.sv
// Requester / config bus of the PMT lookup front end.
//   req_valid/req_addr/req_ready : per-requester lookup request, one-hot grant
//   rsp_valid/rsp_data/rsp_hit   : one-hot response strobe, shared data and hit bit
//   cfg_wr_*                     : table write channel
//   cfg_freeze/cfg_freeze_ack    : lookup quiesce handshake
// Handshake: a transfer happens in any cycle where valid and ready are both 1;
// ready never depends on anything but the current valid/address/state, and a
// requester holds valid (and its address) until it sees ready. Responses have
// no ready: the requester must accept rsp_valid in the cycle it appears.
interface pmt_lookup_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic                       rsp_hit;
    logic                       cfg_wr_valid;
    logic [ADDR_WIDTH-1:0]      cfg_wr_addr;
    logic [DATA_WIDTH-1:0]      cfg_wr_data;
    logic                       cfg_wr_ready;
    logic                       cfg_freeze;
    logic                       cfg_freeze_ack;

    modport master (
        output req_valid, req_addr, cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_freeze,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, cfg_wr_ready, cfg_freeze_ack
    );

    modport slave (
        input  req_valid, req_addr, cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_freeze,
        output req_ready, rsp_valid, rsp_data, rsp_hit, cfg_wr_ready, cfg_freeze_ack
    );
endinterface

// File: rtl/pmt_lookup_arbiter_rr.sv
// Round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   req_i      : eligible requesters
//   advance_i  : move the pointer to this cycle's winner
//   grant_o    : one-hot grant (at most one bit)
//   idx_o      : index of the granted requester
//   any_o      : a grant is issued this cycle
// The search starts one past the last winner; the pointer resets to NREQ-1 so
// requester 0 is first in line after reset.
module pmt_rr_arbiter
    import pmt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    logic [IW-1:0] ptr_q, ptr_d;

    // Wrap without ever forming an out-of-range index, so non-power-of-two
    // NREQ works too.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!any_o && req_i[rr_idx(ptr_q, off)]) begin
                any_o                        = 1'b1;
                idx_o                        = rr_idx(ptr_q, off);
                grant_o[rr_idx(ptr_q, off)]  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && any_o) ptr_d = idx_o;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= IW'(NREQ - 1);
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pmt_lookup_arbiter.sv
// PMT SRAM front end: round-robin lookup arbitration onto the SRAM read port,
// config writes onto the write port, in-flight tag tracking through the fixed
// read latency, response demux and a freeze/drain handshake for atomic updates.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : requester / config bus (see pmt_lookup_arbiter_if)
//   sram_wr_*_o       : SRAM write port, combinational from cfg_wr_*
//   sram_rd_en/addr_o : SRAM read port, combinational from the grant
//   sram_rd_data_i    : SRAM read data, PMT_RD_LAT cycles after sram_rd_en_o
//   sram_rd_valid_i   : entry-programmed bit returned with the data
//   state_dbg_o       : current quiesce FSM state
module pmt_lookup_arbiter
    import pmt_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    pmt_lookup_arbiter_if.slave   bus,
    output logic                  sram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wr_data_o,
    output logic                  sram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] sram_rd_data_i,
    input  logic                  sram_rd_valid_i,
    output pmt_state_e            state_dbg_o
);
    localparam int IW = idx_w(NREQ);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } tag_t;

    pmt_state_e      state_q, state_d;
    logic            ack_q, ack_d;
    logic            grant_en;
    logic            drained;
    logic [NREQ-1:0] elig, req_masked, gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    tag_t            tag_d;
    tag_t            tag_q [PMT_RD_LAT];

    // A requester reading the address being written this cycle sits out, so
    // it is granted later and sees the new data (write-before-read).
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] &&
                      !(bus.cfg_wr_valid &&
                        (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.cfg_wr_addr));
        end
        req_masked = grant_en ? elig : '0;
    end

    pmt_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_masked),
        .advance_i (gnt_any),
        .grant_o   (gnt),
        .idx_o     (gnt_idx),
        .any_o     (gnt_any)
    );

    // Drained once no tag remains that would still respond after this cycle;
    // the last stage is delivering its response now.
    always_comb begin
        drained = 1'b1;
        for (int s = 0; s < PMT_RD_LAT - 1; s++) begin
            if (tag_q[s].valid) drained = 1'b0;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (bus.cfg_freeze) state_d = ST_DRAIN;
            ST_DRAIN:  if (!bus.cfg_freeze) state_d = ST_RUN;
                       else if (drained)    state_d = ST_FROZEN;
            ST_FROZEN: if (!bus.cfg_freeze) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM: outputs. Freeze blocks grants in the very cycle it is raised.
    // The ack is registered on the next state so it rises on FROZEN entry and
    // falls on RUN entry.
    always_comb begin
        grant_en = (state_q == ST_RUN) && !bus.cfg_freeze && !rst;
        ack_d    = (state_d == ST_FROZEN);
    end

    // Tag pipe: one stage per cycle of SRAM read latency.
    always_comb begin
        tag_d.valid = gnt_any;
        tag_d.idx   = gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PMT_RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < PMT_RD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Response demux from the last tag stage; suppressed while in reset.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_hit   = 1'b0;
        if (tag_q[PMT_RD_LAT-1].valid && !rst) begin
            bus.rsp_valid[tag_q[PMT_RD_LAT-1].idx] = 1'b1;
            bus.rsp_data = sram_rd_data_i;
            bus.rsp_hit  = sram_rd_valid_i;
        end
    end

    assign bus.req_ready      = gnt;
    assign bus.cfg_wr_ready   = !rst;
    assign bus.cfg_freeze_ack = ack_q;
    assign sram_wr_en_o       = bus.cfg_wr_valid && !rst;
    assign sram_wr_addr_o     = bus.cfg_wr_addr;
    assign sram_wr_data_o     = bus.cfg_wr_data;
    assign sram_rd_en_o       = gnt_any;
    assign sram_rd_addr_o     = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign state_dbg_o        = state_q;
endmodule

// File: tb/tb_pmt_lookup_arbiter.sv
module tb_pmt_lookup_arbiter;
    import pmt_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int EW   = 32 + NREQ + DW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pmt_lookup_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          sram_wr_en, sram_rd_en;
    logic [AW-1:0] sram_wr_addr, sram_rd_addr;
    logic [DW-1:0] sram_wr_data;
    logic [DW-1:0] sram_rd_data = '0;
    logic          sram_rd_valid = 1'b0;
    pmt_state_e    state_dbg;

    pmt_lookup_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .sram_wr_en_o    (sram_wr_en),
        .sram_wr_addr_o  (sram_wr_addr),
        .sram_wr_data_o  (sram_wr_data),
        .sram_rd_en_o    (sram_rd_en),
        .sram_rd_addr_o  (sram_rd_addr),
        .sram_rd_data_i  (sram_rd_data),
        .sram_rd_valid_i (sram_rd_valid),
        .state_dbg_o     (state_dbg)
    );

    // ---------------- SRAM model: 2-cycle read latency ----------------
    logic [DW-1:0] mem   [32];
    logic          mem_v [32];
    logic          rd1_en = 1'b0;
    logic [AW-1:0] rd1_addr = '0;
    initial for (int i = 0; i < 32; i++) begin mem[i] = '0; mem_v[i] = 1'b0; end
    always @(posedge clk) begin
        if (sram_wr_en) begin
            mem[sram_wr_addr]   <= sram_wr_data;
            mem_v[sram_wr_addr] <= 1'b1;
        end
        rd1_en        <= sram_rd_en;
        rd1_addr      <= sram_rd_addr;
        sram_rd_data  <= rd1_en ? mem[rd1_addr] : '0;
        sram_rd_valid <= rd1_en & mem_v[rd1_addr];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0]  sh_data [32];
    logic           sh_v    [32];
    initial for (int i = 0; i < 32; i++) begin sh_data[i] = '0; sh_v[i] = 1'b0; end

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: each expected entry carries its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [EW-1:0] e;
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                e = exp_q.pop_front();
                chk("rsp_lost", EW'(cyc), EW'(e[EW-1 -: 32]));
            end
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
                e = exp_q.pop_front();
                chk("rsp", {32'(cyc), bus.rsp_valid, bus.rsp_data, bus.rsp_hit}, e);
            end else if (bus.rsp_valid !== '0) begin
                chk("rsp_unexp", EW'(bus.rsp_valid), '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] addrs,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic frz, input logic [NREQ-1:0] exp_rdy, input logic exp_ack,
                        input bit push, input string tag);
        bus.req_valid    = v;
        bus.req_addr     = addrs;
        bus.cfg_wr_valid = wv;
        bus.cfg_wr_addr  = wa;
        bus.cfg_wr_data  = wd;
        bus.cfg_freeze   = frz;
        @(negedge clk);
        chk({tag, "_ready"}, EW'(bus.req_ready), EW'(exp_rdy));
        chk({tag, "_ack"},   EW'(bus.cfg_freeze_ack), EW'(exp_ack));
        chk({tag, "_wr"},    EW'({bus.cfg_wr_ready, sram_wr_en}), EW'({1'b1, wv}));
        if (push && exp_rdy != '0) begin
            logic [AW-1:0] a;
            a = '0;
            for (int g = 0; g < NREQ; g++) if (exp_rdy[g]) a = addrs[g*AW +: AW];
            exp_q.push_back({32'(cyc + 2), exp_rdy, sh_data[a], sh_v[a]});
        end
        if (wv) begin sh_data[wa] = wd; sh_v[wa] = 1'b1; end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, "idle");
    endtask

    task automatic do_reset(input string tag);
        rst              = 1'b1;
        bus.req_valid    = '1;
        bus.req_addr     = NREQ*AW'($urandom);
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_addr  = 5'd31;
        bus.cfg_wr_data  = 32'hDEAD_BEEF;
        bus.cfg_freeze   = 1'b0;
        @(negedge clk);
        chk({tag, "_outs"},
            EW'({bus.req_ready, bus.rsp_valid, bus.cfg_wr_ready, bus.cfg_freeze_ack,
                 sram_wr_en, sram_rd_en}), '0);
        exp_q.delete();
        @(posedge clk); #1;
        rst              = 1'b0;
        bus.req_valid    = '0;
        bus.cfg_wr_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_valid = '0; bus.req_addr = '0; bus.cfg_wr_valid = 1'b0;
        bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0; bus.cfg_freeze = 1'b0;
        @(posedge clk); #1;
        do_reset("reset0");
        mon_en = 1'b1;

        // 1: first grant after reset goes to requester 0, unprogrammed entry
        step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b1, "t1");
        idle(2);

        // 2: write then read it back, then an unprogrammed neighbour
        step('0, '0, 1'b1, 5'd5, 32'hA5A5_0001, 1'b0, '0, 1'b0, 1'b1, "t2_wr");
        step(4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 1'b0, '0, '0, 1'b0, 4'b0010, 1'b0, 1'b1, "t2_hit");
        step(4'b0010, {5'd0, 5'd0, 5'd6, 5'd0}, 1'b0, '0, '0, 1'b0, 4'b0010, 1'b0, 1'b1, "t2_miss");
        idle(2);

        // 3: all requesting, from a fresh pointer
        do_reset("reset3");
        for (int k = 0; k < 6; k++)
            step(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, '0, '0, 1'b0,
                 4'(1 << (k % 4)), 1'b0, 1'b1, "t3");
        idle(2);

        // 4: same-address write masks req0; it reads the new data next cycle
        step(4'b0011, {5'd0, 5'd0, 5'd3, 5'd7}, 1'b1, 5'd7, 32'h77, 1'b0, 4'b0010, 1'b0, 1'b1, "t4_mask");
        step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b1, "t4_late");
        idle(2);

        // 5: freeze with two reads in flight, then release
        step(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b0, '0, '0, 1'b0, 4'b0100, 1'b0, 1'b1, "t5_a");
        step(4'b1000, {5'd7, 5'd0, 5'd0, 5'd0}, 1'b0, '0, '0, 1'b0, 4'b1000, 1'b0, 1'b1, "t5_b");
        step(4'b1111, '0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b1, "t5_frz0");
        step(4'b1111, '0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b1, "t5_drain");
        step(4'b1111, '0, 1'b1, 5'd9, 32'h99, 1'b1, '0, 1'b1, 1'b1, "t5_frozen");
        step(4'b1111, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, "t5_rel");
        step(4'b1111, {5'd0, 5'd0, 5'd0, 5'd9}, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b1, "t5_resume");
        idle(2);

        // 6: reset with two reads in flight; their responses must vanish
        step(4'b0011, {5'd0, 5'd0, 5'd5, 5'd7}, 1'b0, '0, '0, 1'b0, 4'b0010, 1'b0, 1'b0, "t6_a");
        step(4'b0011, {5'd0, 5'd0, 5'd5, 5'd7}, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b0, "t6_b");
        do_reset("t6_rst");
        step(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b1, "t6_next");
        idle(3);

        // Random lookups against a round-robin reference from a known pointer
        do_reset("reset_rnd");
        begin
            int p;
            p = NREQ - 1;
            for (int k = 0; k < 24; k++) begin
                logic [NREQ-1:0]    v, e;
                logic [NREQ*AW-1:0] ad;
                v = 4'($urandom_range(0, 15));
                for (int i = 0; i < NREQ; i++) ad[i*AW +: AW] = 5'($urandom_range(0, 9));
                e = '0;
                for (int off = 1; off <= NREQ; off++) begin
                    int c;
                    c = (p + off) % NREQ;
                    if (e == '0 && v[c]) begin e[c] = 1'b1; p = c; end
                end
                step(v, ad, 1'b0, '0, '0, 1'b0, e, 1'b0, 1'b1, "rnd");
            end
        end
        idle(3);

        chk("exp_q_empty", EW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
